// File: rtl/reg_chain_ctrl.sv
// Register chain of DEPTH x WIDTH stages seeded on load and advanced under
// enable and a prescaler in shift, rotate, increment or hold mode.
//
// state | meaning
// IDLE  | after reset; stages hold, en ignored
// RUN   | chain advances on each prescaled tick
// DONE  | DEPTH-1 advances completed; stages hold until the next load
module reg_chain_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int LED_W    = 16,
  parameter int PRESCALE = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] init_num,
  input  logic [7:0]       switch,
  output logic [LED_W-1:0] led,
  output logic             busy,
  output logic             done
);

  localparam int PS_W   = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int STEP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PS_W-1:0]   PS_MAX    = PS_W'(PRESCALE);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DEPTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {M_SHIFT, M_ROTATE, M_INCR, M_HOLD} mode_t;

  state_t            state;
  mode_t             mode_q;
  logic [STEP_W-1:0] step_cnt;
  logic [PS_W-1:0]   ps_cnt;
  logic [WIDTH-1:0]  r [DEPTH];
  logic [WIDTH-1:0]  sel;

  // switch is 8 bits wide, so anything at or beyond DEPTH reads as zero
  always_comb begin
    sel = '0;
    if (int'(switch) < DEPTH) sel = r[switch[STEP_W-1:0]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
      state    <= IDLE;
      mode_q   <= M_SHIFT;
      step_cnt <= '0;
      ps_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      led      <= '0;
    end else begin
      done <= 1'b0;
      led  <= LED_W'(sel);
      if (load) begin
        r[0] <= init_num;
        for (int i = 1; i < DEPTH; i++) r[i] <= '0;
        mode_q   <= mode_t'(mode);
        step_cnt <= '0;
        ps_cnt   <= '0;
        state    <= RUN;
        busy     <= 1'b1;
      end else if (state == RUN && en) begin
        if (ps_cnt == PS_MAX) begin
          ps_cnt   <= '0;
          step_cnt <= step_cnt + STEP_W'(1);
          case (mode_q)
            M_SHIFT: begin
              r[0] <= '0;
              for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
            end
            M_ROTATE: begin
              r[0] <= r[DEPTH-1];
              for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
            end
            M_INCR: begin
              for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1] + WIDTH'(1);
            end
            default: ;
          endcase
          if (step_cnt == LAST_STEP) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          ps_cnt <= ps_cnt + PS_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/reg_chain_ctrl.md
Name: reg_chain_ctrl

Overview:
- Parametrised register chain: DEPTH stages of WIDTH bits, seeded from init_num, advanced stage to stage under enable and a programmable prescaler.
- Three propagation modes: shift, rotate, increment-per-stage.
- Any stage can be selected onto the led bus for board observation.
- Sits under the SoC top and is driven by the board switch and init_num inputs.

Parameters:
- WIDTH, 8, data width of each stage (1..16).
- DEPTH, 8, number of stages (2..256).
- LED_W, 16, width of led output; must be >= WIDTH.
- PRESCALE, 0, idle cycles between advances; 0 means advance every enabled cycle.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  advance enable; when low, the chain and prescaler freeze.
- load  input  1  single-cycle pulse; seeds the chain and starts a run.
- mode  input  2  propagation mode, sampled on load: 00 SHIFT, 01 ROTATE, 10 INCR, 11 HOLD.
- init_num  input  WIDTH  seed value written to stage 0 on load.
- switch  input  8  stage index to display.
- led  output  LED_W  selected stage, zero-extended, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async, resetn=0):
  - all stages = 0, state = IDLE, step_cnt = 0, prescale counter = 0.
  - led = 0, busy = 0, done = 0, latched mode = 00.
- Reset mid-run aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- load, accepted in any state, has highest priority. On the clk edge where load=1:
  - r[0] <= init_num; r[1..DEPTH-1] <= 0.
  - latched mode <= mode; step_cnt <= 0; prescale counter <= 0; state <= RUN.
- Advance tick, RUN only: tick = en && (prescale counter == PRESCALE).
  - When en=1 and there is no tick, the prescale counter increments.
  - On a tick, the prescale counter clears to 0.
  - When en=0, the counter holds its value.
- On tick, for i = 1..DEPTH-1, r[i] <= r[i-1] in SHIFT and ROTATE, or r[i-1]+1 (mod 2^WIDTH) in INCR. Stage 0 updates as:
  - SHIFT: r[0] <= 0.
  - ROTATE: r[0] <= r[DEPTH-1].
  - INCR: r[0] holds.
  - HOLD: no stage changes, but step_cnt still counts.
- step_cnt increments on each tick.
- On the tick where step_cnt == DEPTH-2 (the (DEPTH-1)th advance), state <= DONE.
- done = 1 for exactly the first cycle in DONE; busy = 1 iff state == RUN.
- IDLE and DONE: stages hold; en is ignored.
- The mode input is ignored except on load; changing it mid-run has no effect.
- led is registered: led <= (switch < DEPTH) ? zero-extended r[switch] : 0.
  - Latency is 1 cycle from a switch change or stage update.
  - Out-of-range switch gives 0.
- A load in the same cycle as a tick: load wins; the tick is discarded.

Test Plan:
- SHIFT, seed and propagate (DEPTH=8, WIDTH=8, PRESCALE=0): release reset, switch=5, init_num=2, mode=00, load pulse, en=1.
  - led=0x0002 one cycle after the 5th tick; busy drops and done pulses after the 7th tick.
  - switch=7 then gives led=0x0002; switch=0 gives 0x0000.
- INCR (same settings, mode=10):
  - After 7 ticks: r0=2, r5=7, r7=9.
  - led=0x0007 at switch=5 and 0x0009 at switch=7.
  - r0 stays 2 throughout.
- ROTATE (mode=01, seed 0xA5):
  - After 7 ticks r7=0xA5, and the run ends.
  - A re-load with seed 0x3C clears r1..r7, and the cycle repeats with 0x3C.
- PRESCALE=3 with en toggling:
  - Ticks occur every 4 enabled cycles.
  - Holding en=0 for 10 cycles mid-run freezes step_cnt, the stages and the prescale counter; done is delayed by exactly 10 cycles.
- Reset and load corner cases:
  - Assert resetn=0 after 3 ticks: all outputs read 0 within the same cycle, and no done pulse occurs.
  - Load during DONE restarts the run with busy=1 on the next cycle.
  - Load coincident with a tick discards the tick: r1 = 0 after the load.
- Out-of-range select: switch=8 or switch=255 -> led=0x0000 regardless of chain contents.
